// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared geometry, types and the sequencer state encoding for the cache miss
// handler and its victim selector.
//   s_index  : set index bits (8 sets)
//   s_assoc  : ways per set
//   s_width  : way-number width
//   s_offset : line offset bits (32-byte line)
//   s_tag    : tag bits of a 32-bit address
//   s_line   : line width in bits
// ---------------------------------------------------------------------------
package cache_pkg;
   localparam int s_index  = 3;
   localparam int s_assoc  = 8;
   localparam int s_width  = $clog2(s_assoc);
   localparam int s_offset = 5;
   localparam int s_tag    = 32 - s_index - s_offset;
   localparam int s_line   = 256;

   typedef logic [s_line-1:0] line_t;

   typedef enum logic [2:0] {
      IDLE,
      LRU_RD,
      SELECT,
      WB_RD,
      WB,
      FILL,
      COMMIT
   } state_t;
endpackage

// File: rtl/victim_select.sv
// ---------------------------------------------------------------------------
// victim_select
// Combinational replacement choice for one set.
//   way_valid  in  : valid bits of the set
//   plru_way   in  : least-recently-used way reported by the PLRU array
//   plru_valid in  : PLRU state for the set is meaningful
//   victim     out : way to replace
// Any invalid way wins (lowest number first), even over a valid PLRU answer;
// a full set uses the PLRU way, and a full set with no PLRU history uses 0.
// ---------------------------------------------------------------------------
module victim_select
   import cache_pkg::*;
(
   input  logic [s_assoc-1:0] way_valid,
   input  logic [s_width-1:0] plru_way,
   input  logic               plru_valid,
   output logic [s_width-1:0] victim
);

   always_comb begin
      victim = plru_valid ? plru_way : '0;
      // Scan from the top down so the lowest-numbered invalid way is the
      // last assignment and therefore the one that sticks.
      for (int w = s_assoc - 1; w >= 0; w--) begin
         if (!way_valid[w]) begin
            victim = s_width'(w);
         end
      end
   end

endmodule

// File: rtl/cache_miss_handler.sv
// ---------------------------------------------------------------------------
// cache_miss_handler
// Miss/replacement sequencer: reads the set's PLRU way, picks a victim, writes
// a dirty victim back, fetches the missing line, then commits it to the
// data/tag arrays and marks the filled way MRU.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   miss_req, miss_addr      miss request (held until miss_done) and address
//   way_valid/dirty/tag      state of the addressed set
//   plru_read, plru_index    PLRU read strobe (data returns next cycle)
//   plru_way, plru_valid     PLRU answer
//   plru_load, plru_hit      PLRU update with one-hot filled way
//   line_read, line_way      victim read strobe / way for read and fill
//   line_rdata               victim line data
//   pmem_*                   line-granular memory port (one-cycle pmem_resp)
//   fill_load/index/tag/data array write of the fetched line
//   miss_done                one-cycle completion pulse
// All strobes are decodes of the registered state, so they change only on
// clock edges (and drop immediately on rst).
// ---------------------------------------------------------------------------
module cache_miss_handler
   import cache_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     miss_req,
   input  logic [31:0]              miss_addr,
   input  logic [s_assoc-1:0]       way_valid,
   input  logic [s_assoc-1:0]       way_dirty,
   input  logic [s_assoc*s_tag-1:0] way_tag,
   output logic                     plru_read,
   output logic [s_index-1:0]       plru_index,
   input  logic [s_width-1:0]       plru_way,
   input  logic                     plru_valid,
   output logic                     plru_load,
   output logic [s_assoc-1:0]       plru_hit,
   output logic                     line_read,
   output logic [s_width-1:0]       line_way,
   input  logic [s_line-1:0]        line_rdata,
   output logic                     pmem_read,
   output logic                     pmem_write,
   output logic [31:0]              pmem_address,
   output logic [s_line-1:0]        pmem_wdata,
   input  logic [s_line-1:0]        pmem_rdata,
   input  logic                     pmem_resp,
   output logic                     fill_load,
   output logic [s_index-1:0]       fill_index,
   output logic [s_tag-1:0]         fill_tag,
   output logic [s_line-1:0]        fill_data,
   output logic                     miss_done
);

   state_t             state_reg, state_next;
   logic [s_tag-1:0]   tag_reg;
   logic [s_index-1:0] index_reg;
   logic [s_width-1:0] victim_reg;
   logic [s_tag-1:0]   victim_tag_reg;
   line_t              wb_buf_reg;
   line_t              fill_buf_reg;

   logic [s_width-1:0] victim_next;
   logic               victim_dirty;
   logic [s_tag-1:0]   tag_arr [s_assoc];

   // The line offset never reaches memory: every access is line-aligned.
   logic               unused_offset;
   assign unused_offset = ^miss_addr[s_offset-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < s_assoc; gi++) begin : g_tag
         assign tag_arr[gi] = way_tag[gi*s_tag +: s_tag];
      end
   endgenerate

   victim_select u_victim_select (
      .way_valid  (way_valid),
      .plru_way   (plru_way),
      .plru_valid (plru_valid),
      .victim     (victim_next)
   );

   // Only meaningful in SELECT, when the PLRU answer is on plru_way.
   assign victim_dirty = way_valid[victim_next] & way_dirty[victim_next];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         tag_reg        <= '0;
         index_reg      <= '0;
         victim_reg     <= '0;
         victim_tag_reg <= '0;
         wb_buf_reg     <= '0;
         fill_buf_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && miss_req) begin
            tag_reg   <= miss_addr[31 -: s_tag];
            index_reg <= miss_addr[s_offset +: s_index];
         end
         if (state_reg == SELECT) begin
            victim_reg     <= victim_next;
            victim_tag_reg <= tag_arr[victim_next];
         end
         if (state_reg == WB_RD) begin
            wb_buf_reg <= line_rdata;
         end
         if (state_reg == FILL && pmem_resp) begin
            fill_buf_reg <= pmem_rdata;
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      plru_read    = 1'b0;
      plru_load    = 1'b0;
      plru_hit     = '0;
      line_read    = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      fill_load    = 1'b0;
      miss_done    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (miss_req) state_next = LRU_RD;
         end
         LRU_RD: begin
            plru_read  = 1'b1;
            state_next = SELECT;
         end
         SELECT: begin
            state_next = victim_dirty ? WB_RD : FILL;
         end
         WB_RD: begin
            line_read  = 1'b1;
            state_next = WB;
         end
         WB: begin
            pmem_write   = 1'b1;
            pmem_address = {victim_tag_reg, index_reg, {s_offset{1'b0}}};
            if (pmem_resp) state_next = FILL;
         end
         FILL: begin
            pmem_read    = 1'b1;
            pmem_address = {tag_reg, index_reg, {s_offset{1'b0}}};
            if (pmem_resp) state_next = COMMIT;
         end
         COMMIT: begin
            fill_load  = 1'b1;
            plru_load  = 1'b1;
            plru_hit   = s_assoc'(1) << victim_reg;
            miss_done  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign plru_index = index_reg;
   assign line_way   = victim_reg;
   assign pmem_wdata = wb_buf_reg;
   assign fill_index = index_reg;
   assign fill_tag   = tag_reg;
   assign fill_data  = fill_buf_reg;

endmodule
